rom_loader: RTL

Parametrised download router between the HPS ioctl stream and the core's ROM, DIP and mod storage. It decodes ioctl writes for N address-mapped ROM regions and packs bytes into DW-bit words. It captures DIP bytes (index 254) and the mod byte (index 1). It also sequences core reset across a download: reset is held during the download and for a fixed number of cycles after it.

---
 rtl/rom_loader_pkg.sv | 19 +
 rtl/rom_region_decode.sv | 39 +++
 rtl/rom_loader.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/rom_loader_pkg.sv
// rom_loader_pkg: shared FSM states, stream indices and region parameter unpacking.
package rom_loader_pkg;

    typedef enum logic [1:0] {RUN, LOAD, FLUSH, HOLD} state_e;

    localparam logic [7:0] IDX_ROM = 8'd0;
    localparam logic [7:0] IDX_MOD = 8'd1;
    localparam logic [7:0] IDX_DIP = 8'd254;

    typedef struct packed {
        logic [24:0] base;
        logic [4:0]  aw;
    } region_t;

    function automatic region_t region_cfg(input logic [199:0] bases, input logic [39:0] aws, input int i);
        return '{base: bases[25*i +: 25], aw: aws[5*i +: 5]};
    endfunction

endpackage

// File: rtl/rom_region_decode.sv
// rom_region_decode: maps a byte address onto the lowest-indexed matching ROM region.
module rom_region_decode
    import rom_loader_pkg::*;
#(
    parameter int           NUM_REGIONS = 3,
    parameter logic [199:0] REGION_BASE = {8{25'h0}},
    parameter logic [39:0]  REGION_AW   = {8{5'd15}}
) (
    input  logic [24:0]            addr_i,
    output logic                   hit_o,
    output logic [NUM_REGIONS-1:0] sel_o,
    output logic [24:0]            off_o
);

    logic [NUM_REGIONS-1:0] match;
    logic [24:0]            offs [NUM_REGIONS];

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        localparam region_t CFG = region_cfg(REGION_BASE, REGION_AW, i);
        // 26-bit compare so a region ending exactly at 2^25 still decodes
        assign match[i] = (addr_i >= CFG.base) &&
                          ({1'b0, addr_i} < ({1'b0, CFG.base} + (26'd1 << CFG.aw)));
        assign offs[i]  = addr_i - CFG.base;
    end

    always_comb begin
        hit_o = |match;
        sel_o = '0;
        off_o = '0;
        for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
            if (match[k]) begin
                sel_o    = '0;
                sel_o[k] = 1'b1;
                off_o    = offs[k];
            end
        end
    end

endmodule

// File: rtl/rom_loader.sv
// rom_loader: routes the ioctl download stream into ROM regions, DIP and mod registers,
// packing bytes into DW-bit words and holding core reset across each download.
module rom_loader
    import rom_loader_pkg::*;
#(
    parameter int           NUM_REGIONS = 3,
    parameter logic [199:0] REGION_BASE = {8{25'h0}},
    parameter logic [39:0]  REGION_AW   = {8{5'd15}},
    parameter int           DW          = 8,
    parameter int           DIP_BYTES   = 8,
    parameter int           RESET_HOLD  = 16
) (
    input  logic                     clk_sys,
    input  logic                     reset_n,
    input  logic                     ioctl_download,
    input  logic [7:0]               ioctl_index,
    input  logic                     ioctl_wr,
    input  logic [24:0]              ioctl_addr,
    input  logic [7:0]               ioctl_dout,
    output logic [NUM_REGIONS-1:0]   rom_we,
    output logic [24:0]              rom_addr,
    output logic [DW-1:0]            rom_data,
    output logic [8*DIP_BYTES-1:0]   dip,
    output logic [7:0]               mod,
    output logic                     core_reset_n,
    output logic                     busy,
    output logic [15:0]              miss_cnt
);

    localparam int SH = (DW == 16) ? 1 : 0;
    localparam int CW = $clog2(RESET_HOLD + 1);

    state_e                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     dl_q;
    logic [NUM_REGIONS-1:0]   we_q, we_d, bsel_q, bsel_d, ssel_q, ssel_d;
    logic [24:0]              addr_q, addr_d, baddr_q, baddr_d, saddr_q, saddr_d;
    logic [DW-1:0]            data_q, data_d;
    logic [7:0]               buf_q, buf_d, sbyte_q, sbyte_d, mod_q, mod_d;
    logic                     pend_q, pend_d, split_q, split_d;
    logic [8*DIP_BYTES-1:0]   dip_q, dip_d;
    logic [15:0]              miss_q, miss_d;
    logic                     hit, rom_wr, rise;
    logic [NUM_REGIONS-1:0]   sel;
    logic [24:0]              off, waddr;

    rom_region_decode #(
        .NUM_REGIONS (NUM_REGIONS),
        .REGION_BASE (REGION_BASE),
        .REGION_AW   (REGION_AW)
    ) u_dec (
        .addr_i (ioctl_addr),
        .hit_o  (hit),
        .sel_o  (sel),
        .off_o  (off)
    );

    assign rom_wr = ioctl_wr && ioctl_download && (ioctl_index == IDX_ROM);
    assign rise   = ioctl_download && !dl_q;
    assign waddr  = off >> SH;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN:   state_d = rise ? LOAD : RUN;
            LOAD:  state_d = ioctl_download ? LOAD : FLUSH;
            FLUSH: begin
                state_d = HOLD;
                cnt_d   = '0;
            end
            HOLD: begin
                cnt_d   = cnt_q + 1'b1;
                state_d = rise ? LOAD : (cnt_q == CW'(RESET_HOLD - 1)) ? RUN : HOLD;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        we_d    = '0;
        addr_d  = addr_q;
        data_d  = data_q;
        pend_d  = pend_q;
        buf_d   = buf_q;
        bsel_d  = bsel_q;
        baddr_d = baddr_q;
        split_d = 1'b0;
        ssel_d  = ssel_q;
        saddr_d = saddr_q;
        sbyte_d = sbyte_q;
        miss_d  = miss_q;
        mod_d   = mod_q;
        dip_d   = dip_q;
        if (rom_wr && !hit && miss_q != 16'hFFFF)
            miss_d = miss_q + 16'd1;
        if (split_q) begin
            we_d   = ssel_q;
            addr_d = saddr_q;
            data_d = DW'({sbyte_q, 8'h00});
        end else if (state_q == FLUSH && pend_q) begin
            we_d   = bsel_q;
            addr_d = baddr_q;
            data_d = DW'({8'h00, buf_q});
            pend_d = 1'b0;
        end else if (rom_wr && hit) begin
            if (DW == 8) begin
                we_d   = sel;
                addr_d = waddr;
                data_d = DW'(ioctl_dout);
            end else if (!off[0]) begin
                // a second low byte before its partner retires the older one half-filled
                if (pend_q) begin
                    we_d   = bsel_q;
                    addr_d = baddr_q;
                    data_d = DW'({8'h00, buf_q});
                end
                pend_d  = 1'b1;
                buf_d   = ioctl_dout;
                bsel_d  = sel;
                baddr_d = waddr;
            end else if (pend_q && bsel_q == sel && baddr_q == waddr) begin
                we_d   = sel;
                addr_d = waddr;
                data_d = DW'({ioctl_dout, buf_q});
                pend_d = 1'b0;
            end else if (pend_q) begin
                we_d    = bsel_q;
                addr_d  = baddr_q;
                data_d  = DW'({8'h00, buf_q});
                pend_d  = 1'b0;
                split_d = 1'b1;
                ssel_d  = sel;
                saddr_d = waddr;
                sbyte_d = ioctl_dout;
            end else begin
                we_d   = sel;
                addr_d = waddr;
                data_d = DW'({ioctl_dout, 8'h00});
            end
        end
        if (ioctl_wr && ioctl_index == IDX_DIP)
            for (int k = 0; k < DIP_BYTES; k++)
                if (ioctl_addr == 25'(k))
                    dip_d[8*k +: 8] = ioctl_dout;
        if (ioctl_wr && ioctl_index == IDX_MOD && ioctl_addr == '0)
            mod_d = ioctl_dout;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            dl_q    <= 1'b0;
            we_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            pend_q  <= 1'b0;
            buf_q   <= '0;
            bsel_q  <= '0;
            baddr_q <= '0;
            split_q <= 1'b0;
            ssel_q  <= '0;
            saddr_q <= '0;
            sbyte_q <= '0;
            miss_q  <= '0;
            mod_q   <= '0;
            dip_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dl_q    <= ioctl_download;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            pend_q  <= pend_d;
            buf_q   <= buf_d;
            bsel_q  <= bsel_d;
            baddr_q <= baddr_d;
            split_q <= split_d;
            ssel_q  <= ssel_d;
            saddr_q <= saddr_d;
            sbyte_q <= sbyte_d;
            miss_q  <= miss_d;
            mod_q   <= mod_d;
            dip_q   <= dip_d;
        end
    end

    assign rom_we       = we_q;
    assign rom_addr     = addr_q;
    assign rom_data     = data_q;
    assign dip          = dip_q;
    assign mod          = mod_q;
    assign miss_cnt     = miss_q;
    assign core_reset_n = (state_q == RUN);
    assign busy         = (state_q == LOAD) || (state_q == HOLD);

endmodule
